mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and load/store (D).
// Optional wait-cycle counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   i_wait_cnt,
    output logic [31:0]   d_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          win_i, win_d;
    logic          busy;

    // Grant decision: D wins outright when alone, or on a tie when I was served last.
    always_comb begin
        win_d = d_req & (~i_req | (last_q == SEL_I));
        win_i = i_req & ~win_d;
        busy  = (state_q == ACCESS) || (state_q == RESP);
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wd_d      = wd_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (win_d) begin
                    sel_d   = SEL_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wd_d    = d_wdata;
                    state_d = ACCESS;
                end else if (win_i) begin
                    sel_d   = SEL_I;
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                    wd_d    = {DW{1'b0}};
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (sel_q == SEL_I) begin
                    i_rdata_d = mem_rd;
                end else if (!we_q) begin
                    d_rdata_d = mem_rd;
                end else begin
                    d_rdata_d = d_rdata_q;
                end
                last_d  = sel_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= SEL_I;
            last_q    <= SEL_D;
            addr_q    <= {AW{1'b0}};
            we_q      <= 1'b0;
            wd_q      <= {DW{1'b0}};
            i_rdata_q <= {DW{1'b0}};
            d_rdata_q <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wd_q      <= wd_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Memory port is driven only during ACCESS and decoded purely from registers.
    always_comb begin
        i_ready = (state_q == RESP) && (sel_q == SEL_I);
        d_ready = (state_q == RESP) && (sel_q == SEL_D);
        i_rdata = i_rdata_q;
        d_rdata = d_rdata_q;
        if (state_q == ACCESS) begin
            mem_we = we_q;
            mem_a  = addr_q & WORD_MASK;
            mem_wd = wd_q;
        end else begin
            mem_we = 1'b0;
            mem_a  = {AW{1'b0}};
            mem_wd = {DW{1'b0}};
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] i_wait_q, i_wait_d;
    logic [31:0] d_wait_q, d_wait_d;

    // A requester is waiting when it loses the grant or another transaction occupies the port.
    always_comb begin
        i_wait_d = i_wait_q;
        d_wait_d = d_wait_q;
        if (((state_q == IDLE) && i_req && win_d) || (busy && i_req && (sel_q != SEL_I))) begin
            i_wait_d = i_wait_q + 32'd1;
        end else begin
            i_wait_d = i_wait_q;
        end
        if (((state_q == IDLE) && d_req && win_i) || (busy && d_req && (sel_q != SEL_D))) begin
            d_wait_d = d_wait_q + 32'd1;
        end else begin
            d_wait_d = d_wait_q;
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_wait_q <= 32'd0;
            d_wait_q <= 32'd0;
        end else begin
            i_wait_q <= i_wait_d;
            d_wait_q <= d_wait_d;
        end
    end

    assign i_wait_cnt = i_wait_q;
    assign d_wait_cnt = d_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small behavioural word memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] i_wait_cnt;
    logic [31:0] d_wait_cnt;
`endif

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef MEM_ARB_PERF_EN
        , .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:63];
    assign mem_rd = tb_mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_a[7:2]] <= mem_wd;
    end

    typedef struct {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each ready pulse pops the oldest expected completion.
    always @(negedge clk) begin
        if (!reset && (i_ready || d_ready)) begin
            if (sb.size() == 0) begin
                check_val("unexp_ready", {62'd0, i_ready, d_ready}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("ready_port", {62'd0, i_ready, d_ready}, e.is_d ? 64'd1 : 64'd2);
                if (e.chk) check_val("rdata", e.is_d ? d_rdata : i_rdata, e.data);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic do_req(input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input logic chk);
        exp_t e;
        int   lat;
        logic seen;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        e.is_d = is_d; e.chk = chk; e.data = exp_data;
        sb.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check_val("acc_addr", mem_a, {addr[31:2], 2'b00});
                check_val("acc_we", mem_we, we & is_d);
                check_val("acc_wd", mem_wd, (we & is_d) ? wdata : mem_wd);
            end
            if (i_ready || d_ready) begin
                seen = 1'b1;
                lat  = k;
                check_val("resp_we", mem_we, 1'b0);
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        check_val("ready_seen", seen, 1'b1);
        check_val("latency", lat, 2);
        @(posedge clk); #1;
        check_val("ready_pulse", {i_ready, d_ready}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
        tb_mem[2] = 32'h2002_0005;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        do_reset();

        check_val("rst_i_ready", i_ready, 1'b0);
        check_val("rst_d_ready", d_ready, 1'b0);
        check_val("rst_mem_we", mem_we, 1'b0);
        check_val("rst_mem_a", mem_a, 32'h0);
        check_val("rst_i_rdata", i_rdata, 32'h0);
        check_val("rst_d_rdata", d_rdata, 32'h0);
`ifdef MEM_ARB_PERF_EN
        check_val("rst_i_wait", i_wait_cnt, 32'd0);
        check_val("rst_d_wait", d_wait_cnt, 32'd0);
`endif

        do_req(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h2002_0005, 1'b1);
        do_req(1'b1, 1'b1, 32'h0000_0054, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check_val("store_commit", tb_mem[21], 32'hDEAD_BEEF);
        check_val("store_no_rdata", d_rdata, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0054, 32'h0, 32'hDEAD_BEEF, 1'b1);
        check_val("i_rdata_hold", i_rdata, 32'h2002_0005);
        do_req(1'b1, 1'b0, 32'h0000_0057, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Abort a fetch with reset while it is in ACCESS.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0054;
        @(posedge clk); #1;
        check_val("abort_acc_addr", mem_a, 32'h0000_0054);
        reset = 1'b1;
        i_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("abort_i_ready", i_ready, 1'b0);
        check_val("abort_i_rdata", i_rdata, 32'h0);
        check_val("abort_d_rdata", d_rdata, 32'h0);
        check_val("abort_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        check_val("abort_no_ready", {i_ready, d_ready}, 2'b00);
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h2002_0005, 1'b1);

        // Tie with both requests held: I, D, I, D every three cycles.
        do_reset();
        begin
            exp_t e;
            int   rdy_cnt;
            int   last_cyc;
            e.chk = 1'b1;
            e.is_d = 1'b0; e.data = 32'h2002_0005; sb.push_back(e);
            e.is_d = 1'b1; e.data = 32'hDEAD_BEEF; sb.push_back(e);
            e.is_d = 1'b0; e.data = 32'h2002_0005; sb.push_back(e);
            e.is_d = 1'b1; e.data = 32'hDEAD_BEEF; sb.push_back(e);
            i_req = 1'b1; i_addr = 32'h0000_0008;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0054;
            rdy_cnt  = 0;
            last_cyc = 0;
            for (int c = 1; c <= 30 && rdy_cnt < 4; c++) begin
                @(posedge clk); #1;
`ifdef MEM_ARB_PERF_EN
                if (rdy_cnt == 1 && c == last_cyc + 1) check_val("d_wait_cnt", d_wait_cnt, 32'd3);
                if (rdy_cnt == 2 && c == last_cyc + 1) check_val("i_wait_cnt", i_wait_cnt, 32'd3);
`endif
                if (i_ready || d_ready) begin
                    rdy_cnt++;
                    if (rdy_cnt == 1) check_val("rr_first_lat", c, 2);
                    else check_val("rr_spacing", c - last_cyc, 3);
                    last_cyc = c;
                end
            end
            i_req = 1'b0;
            d_req = 1'b0;
            check_val("rr_count", rdy_cnt, 4);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("end_idle", {i_ready, d_ready, mem_we}, 3'b000);
`ifdef MEM_ARB_PERF_EN
        do_reset();
        check_val("clr_i_wait", i_wait_cnt, 32'd0);
        check_val("clr_d_wait", d_wait_cnt, 32'd0);
`endif
        check_val("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
